// File: rtl/tick_ctrl.sv
// tick_ctrl: prescaled one-cycle tick generator with a debounced RUN/PAUSE toggle.
// Build option TICK_STEP_EN adds btn_step for single-step ticks while paused.

module tick_ctrl_btn #(
    parameter int DB_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press_p
);

    logic [1:0]        sync_q;
    logic [1:0]        sync_d;
    logic [DB_LEN-1:0] sr_q;
    logic [DB_LEN-1:0] sr_d;
    logic              db_q;
    logic              db_d;
    logic              db_dly_q;
    logic              db_dly_d;

    // Level only moves once DB_LEN consecutive synchronised samples agree.
    always_comb begin
        sync_d   = {sync_q[0], btn};
        sr_d     = {sr_q[DB_LEN-2:0], sync_q[1]};
        db_d     = db_q;
        if (&sr_q) begin
            db_d = 1'b1;
        end else if (~|sr_q) begin
            db_d = 1'b0;
        end
        db_dly_d = db_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            sr_q     <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            sr_q     <= sr_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
        end
    end

    assign press_p = db_q & ~db_dly_q;

endmodule

module tick_ctrl #(
    parameter int DIV_WIDTH = 27,
    parameter int DIV_MAX   = 99_999_999,
    parameter int DB_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_pause,
`ifdef TICK_STEP_EN
    input  logic btn_step,
`endif
    output logic tick,
    output logic running
);

    localparam logic [DIV_WIDTH-1:0] DIV_TOP = DIV_WIDTH'(DIV_MAX);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [DIV_WIDTH-1:0] div_cnt_d;
    logic                 tick_q;
    logic                 tick_d;
    logic                 pause_p;

    tick_ctrl_btn #(
        .DB_LEN (DB_LEN)
    ) u_btn_pause (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn_pause),
        .press_p (pause_p)
    );

`ifdef TICK_STEP_EN
    logic step_p;

    tick_ctrl_btn #(
        .DB_LEN (DB_LEN)
    ) u_btn_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn_step),
        .press_p (step_p)
    );
`endif

    // Prescaler acts on the current state; a press only affects later cycles.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        tick_d    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (div_cnt_q == DIV_TOP) begin
                    div_cnt_d = '0;
                    tick_d    = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                end
                if (pause_p) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
`ifdef TICK_STEP_EN
                tick_d = step_p;
`endif
                if (pause_p) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign tick    = tick_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_tick_ctrl.sv
// tb_tick_ctrl: randomized and directed checks of tick_ctrl against a
// sample-history reference model (DIV_MAX=3, DB_LEN=4, DIV_WIDTH=2).
module tb_tick_ctrl;

    localparam int DIV_WIDTH = 2;
    localparam int DIV_MAX   = 3;
    localparam int DB_LEN    = 4;
`ifdef TICK_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic btn_pause = 1'b0;
    logic btn_step = 1'b0;
    logic tick;
    logic running;

    int checks = 0;
    int failures = 0;

    // Reference model: raw button samples per edge, newest in bit 0.
    logic [6:0] hp = '0;
    logic [6:0] hs = '0;
    logic m_dbp = 1'b0;
    logic m_dbs = 1'b0;
    logic m_pp = 1'b0;
    logic m_sp = 1'b0;
    logic m_run = 1'b1;
    logic m_tick = 1'b0;
    logic ndp;
    logic nds;
    int m_div = 0;

    tick_ctrl #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_MAX   (DIV_MAX),
        .DB_LEN    (DB_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_pause (btn_pause),
`ifdef TICK_STEP_EN
        .btn_step  (btn_step),
`endif
        .tick      (tick),
        .running   (running)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp = '0;
            hs = '0;
            m_dbp = 1'b0;
            m_dbs = 1'b0;
            m_pp = 1'b0;
            m_sp = 1'b0;
            m_run = 1'b1;
            m_div = 0;
            m_tick = 1'b0;
        end else begin
            m_tick = 1'b0;
            if (m_run) begin
                if (m_div == DIV_MAX) begin
                    m_div = 0;
                    m_tick = 1'b1;
                end else begin
                    m_div = m_div + 1;
                end
            end else if (m_sp) begin
                m_tick = 1'b1;
            end
            if (m_pp) m_run = !m_run;
            // Level seen here is decided by samples 3..6 edges old.
            hp = {hp[5:0], btn_pause};
            hs = {hs[5:0], btn_step};
            ndp = m_dbp;
            if (hp[6:3] == 4'hF) ndp = 1'b1;
            else if (hp[6:3] == 4'h0) ndp = 1'b0;
            nds = m_dbs;
            if (hs[6:3] == 4'hF) nds = 1'b1;
            else if (hs[6:3] == 4'h0) nds = 1'b0;
            m_pp = ndp && !m_dbp;
            m_sp = STEP_EN && nds && !m_dbs;
            m_dbp = ndp;
            m_dbs = nds;
        end
    end

    task automatic test_reset();
        int nt = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tick !== 1'b0 || running !== 1'b1) begin
            failures++;
            $display("FAIL reset_async: tick=%b running=%b expected tick=0 running=1",
                     tick, running);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            checks++;
            if (tick !== m_tick || running !== m_run) begin
                failures++;
                $display("FAIL reset_run cyc%0d: tick=%b running=%b expected %b %b",
                         i, tick, running, m_tick, m_run);
            end
            if (tick === 1'b1) nt++;
        end
        checks++;
        if (nt != 3) begin
            failures++;
            $display("FAIL reset_tick_count: got %0d expected 3", nt);
        end
    endtask

    task automatic test_glitch();
        int nt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            checks++;
            if (tick !== m_tick || running !== m_run) begin
                failures++;
                $display("FAIL glitch cyc%0d: tick=%b running=%b expected %b %b",
                         i, tick, running, m_tick, m_run);
            end
            if (tick === 1'b1) nt++;
            btn_pause = (i < 12) ? ~btn_pause : 1'b0;
        end
        checks++;
        if (running !== 1'b1 || nt != 8) begin
            failures++;
            $display("FAIL glitch_result: running=%b ticks=%0d expected 1 and 8",
                     running, nt);
        end
    endtask

    task automatic test_hold();
        int first_off = -1;
        int pticks = 0;
        int toggles = 0;
        logic prev;
        @(negedge clk);
        prev = running;
        btn_pause = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            checks++;
            if (tick !== m_tick || running !== m_run) begin
                failures++;
                $display("FAIL hold cyc%0d: tick=%b running=%b expected %b %b",
                         i, tick, running, m_tick, m_run);
            end
            if (running === 1'b0 && first_off < 0) first_off = i;
            if (i >= 9 && tick === 1'b1) pticks++;
            if (running !== prev) toggles++;
            prev = running;
        end
        checks++;
        if (first_off != 8 || pticks != 0 || toggles != 1) begin
            failures++;
            $display("FAIL hold_result: edge=%0d pticks=%0d toggles=%0d expected 8 0 1",
                     first_off, pticks, toggles);
        end
        for (int i = 0; i < 36; i++) begin
            btn_pause = (i >= 12 && i < 24);
            @(negedge clk);
            checks++;
            if (tick !== m_tick || running !== m_run) begin
                failures++;
                $display("FAIL resume cyc%0d: tick=%b running=%b expected %b %b",
                         i, tick, running, m_tick, m_run);
            end
        end
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL resume_state: running=%b expected 1", running);
        end
    endtask

    task automatic test_wrap();
        int guard = 0;
        while (!(m_div == 0 && m_run) && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 16) begin
            failures++;
            $display("FAIL wrap_align: model phase not reached, got guard=%0d expected <16",
                     guard);
        end
        btn_pause = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 10) btn_pause = 1'b0;
            checks++;
            if (tick !== m_tick || running !== m_run) begin
                failures++;
                $display("FAIL wrap cyc%0d: tick=%b running=%b expected %b %b",
                         i, tick, running, m_tick, m_run);
            end
            if (i == 8) begin
                checks++;
                if (tick !== 1'b1 || running !== 1'b0) begin
                    failures++;
                    $display("FAIL wrap_edge: tick=%b running=%b expected tick=1 running=0",
                             tick, running);
                end
            end
        end
    endtask

    task automatic test_reset_pause();
        int guard = 0;
        int first = -1;
        for (int i = 0; i < 20; i++) begin
            btn_pause = (i < 10);
            @(negedge clk);
            checks++;
            if (tick !== m_tick || running !== m_run) begin
                failures++;
                $display("FAIL rp_resume cyc%0d: tick=%b running=%b expected %b %b",
                         i, tick, running, m_tick, m_run);
            end
        end
        while (!(m_div == 2 && m_run) && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 20; i++) begin
            btn_pause = (i < 10);
            @(negedge clk);
            checks++;
            if (tick !== m_tick || running !== m_run) begin
                failures++;
                $display("FAIL rp_pause cyc%0d: tick=%b running=%b expected %b %b",
                         i, tick, running, m_tick, m_run);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tick !== 1'b0 || running !== 1'b1) begin
            failures++;
            $display("FAIL rp_async: tick=%b running=%b expected tick=0 running=1",
                     tick, running);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (tick !== m_tick || running !== m_run) begin
                failures++;
                $display("FAIL rp_after cyc%0d: tick=%b running=%b expected %b %b",
                         i, tick, running, m_tick, m_run);
            end
            if (tick === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (first != 4) begin
            failures++;
            $display("FAIL rp_first_tick: edge=%0d expected 4", first);
        end
    endtask

    task automatic test_step();
        int nt = 0;
        int exp_nt;
        for (int i = 0; i < 20; i++) begin
            btn_pause = (i < 10);
            @(negedge clk);
            checks++;
            if (tick !== m_tick || running !== m_run) begin
                failures++;
                $display("FAIL step_enter cyc%0d: tick=%b running=%b expected %b %b",
                         i, tick, running, m_tick, m_run);
            end
        end
        for (int i = 0; i < 48; i++) begin
            btn_step = ((i % 16) < 8);
            @(negedge clk);
            checks++;
            if (tick !== m_tick || running !== m_run) begin
                failures++;
                $display("FAIL step_pause cyc%0d: tick=%b running=%b expected %b %b",
                         i, tick, running, m_tick, m_run);
            end
            if (tick === 1'b1) nt++;
        end
        exp_nt = STEP_EN ? 3 : 0;
        checks++;
        if (nt != exp_nt || running !== 1'b0) begin
            failures++;
            $display("FAIL step_count: ticks=%0d running=%b expected %0d and 0",
                     nt, running, exp_nt);
        end
        for (int i = 0; i < 20; i++) begin
            btn_pause = (i < 10);
            @(negedge clk);
            checks++;
            if (tick !== m_tick || running !== m_run) begin
                failures++;
                $display("FAIL step_resume cyc%0d: tick=%b running=%b expected %b %b",
                         i, tick, running, m_tick, m_run);
            end
        end
        nt = 0;
        for (int i = 0; i < 16; i++) begin
            btn_step = (i < 8);
            @(negedge clk);
            checks++;
            if (tick !== m_tick || running !== m_run) begin
                failures++;
                $display("FAIL step_run cyc%0d: tick=%b running=%b expected %b %b",
                         i, tick, running, m_tick, m_run);
            end
            if (tick === 1'b1) nt++;
        end
        checks++;
        if (nt != 4) begin
            failures++;
            $display("FAIL step_run_count: ticks=%0d expected 4", nt);
        end
    endtask

    task automatic test_random();
        int pc = 0;
        int sc = 0;
        for (int i = 0; i < 800; i++) begin
            if (pc == 0) begin
                btn_pause = 1'($urandom_range(0, 1));
                pc = $urandom_range(1, 12);
            end
            if (sc == 0) begin
                btn_step = 1'($urandom_range(0, 1));
                sc = $urandom_range(1, 12);
            end
            pc--;
            sc--;
            if (i == 400) begin
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if (tick !== 1'b0 || running !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_reset: tick=%b running=%b expected 0 1",
                             tick, running);
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (tick !== m_tick || running !== m_run) begin
                failures++;
                $display("FAIL random cyc%0d: tick=%b running=%b expected %b %b",
                         i, tick, running, m_tick, m_run);
            end
        end
        btn_pause = 1'b0;
        btn_step = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_glitch();
        test_hold();
        test_wrap();
        test_reset_pause();
        test_step();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
